// File: rtl/decrypt_dispatch.sv
// Request dispatcher in front of the decrypt/validate FSM: queues tagged requests,
// pulses start once per request, and watchdogs done with a bounded retry.
module decrypt_dispatch #(
  parameter int ID_W      = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  output logic            start,
  input  logic            done,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_timeout,
  output logic            busy
);

  localparam int AW       = $clog2(DEPTH);
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int WD_BOUND = (MAX_RETRY + 1) * (TIMEOUT + 1) + 1;

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      retry_q, retry_d;
  logic            start_q, rsp_valid_q, rsp_timeout_q, busy_q;
  logic            timeout_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            push_s, pop_s;
  logic [ID_W-1:0] head_s;

  assign req_ready   = (count_q != FULL_CNT);
  assign push_s      = req_valid && req_ready;
  // The head stays queued until its response is accepted, so it is popped only here.
  assign pop_s       = (state_q == ST_RESPOND) && rsp_ready;
  assign head_s      = mem_q[rd_ptr_q];
  assign start       = start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= req_id;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    timeout_d = rsp_timeout_q;
    rsp_id_d  = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_ISSUE;
        else               state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        timer_d = TMR_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done on the final watchdog cycle still counts as success.
        if (done) begin
          state_d   = ST_RESPOND;
          timeout_d = 1'b0;
          rsp_id_d  = head_s;
        end else if (timer_q == TMR_ONE) begin
          timer_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d   = ST_RESPOND;
            timeout_d = 1'b1;
            rsp_id_d  = head_s;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          retry_d = 2'd0;
        end else begin
          state_d = ST_RESPOND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it cycle-for-cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      retry_q       <= 2'd0;
      start_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_id_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      start_q       <= (state_d == ST_ISSUE);
      rsp_valid_q   <= (state_d == ST_RESPOND);
      rsp_timeout_q <= timeout_d;
      rsp_id_q      <= rsp_id_d;
      busy_q        <= (state_d != ST_IDLE) || (count_d != '0);
    end
  end

  logic [31:0] wd_cnt_q;

  // Cycles spent issuing/waiting for the current request, bounding the watchdog property.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_q <= 32'd0;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_q <= 32'd0;
    end
  end

  a_watchdog_bound: assert property (@(posedge clk) disable iff (!rstn)
    wd_cnt_q < 32'(WD_BOUND));

  a_start_single: assert property (@(posedge clk) disable iff (!rstn)
    start |=> !start);

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rstn)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_timeout)));

endmodule

// File: tb/tb_decrypt_dispatch.sv
// Directed bench for decrypt_dispatch: inputs driven and outputs checked on the falling edge.
module tb_decrypt_dispatch;

  logic       clk, rstn, req_valid, req_ready, start, done;
  logic       rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [3:0] req_id, rsp_id;
  int         errors = 0;
  int         checks = 0;

  decrypt_dispatch #(.ID_W(4), .DEPTH(4), .TIMEOUT(16), .MAX_RETRY(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .start(start), .done(done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_id = 4'd0; done = 1'b0; rsp_ready = 1'b0;
    repeat (3) step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", start); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rsp_id !== 4'd0) begin errors++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", rsp_timeout); end
    rstn = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_id = 4'd3;
    step();
    req_valid = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_n1: got %b want 0", start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start_n2: got %b want 1", start); end
    step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_once: got %b want 0", start); end
    step(); step();
    done = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    step();
    done = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 4'd3) begin errors++; $display("FAIL single_rsp_id: got %0d want 3", rsp_id); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", rsp_timeout); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    req_valid = 1'b1; req_id = 4'd1;
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", k, req_ready); end
      req_id = 4'(k);
    end
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", req_ready); end
    req_id = 4'd5; done = 1'b1;
    step();
    done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid: got %b want 1", rsp_valid); end
      checks++; if (rsp_id !== 4'd1) begin errors++; $display("FAIL b2b_hold_id: got %0d want 1", rsp_id); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_holdoff: got %b want 0", req_ready); end
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", req_ready); end
    for (int k = 2; k <= 4; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (start === 1'b1) seen = 1'b1;
        else step();
      end
      checks++; if (!seen) begin errors++; $display("FAIL b2b_start_%0d: got no start want start", k); end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid_%0d: got %b want 1", k, rsp_valid); end
      checks++; if (rsp_id !== 4'(k)) begin errors++; $display("FAIL b2b_rsp_id: got %0d want %0d", rsp_id, k); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drained_busy: got %b want 0", busy); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL b2b_no_extra: got %b want 0", start); end
  endtask

  task automatic test_timeout();
    logic exp_start, exp_valid;
    req_valid = 1'b1; req_id = 4'd7;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL to_start_t: got %b want 1", start); end
    for (int i = 1; i <= 34; i++) begin
      step();
      exp_start = (i == 17);
      exp_valid = (i == 34);
      checks++; if (start !== exp_start) begin errors++; $display("FAIL to_start_t+%0d: got %b want %b", i, start, exp_start); end
      checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL to_rsp_t+%0d: got %b want %b", i, rsp_valid, exp_valid); end
    end
    checks++; if (rsp_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", rsp_timeout); end
    checks++; if (rsp_id !== 4'd7) begin errors++; $display("FAIL to_rsp_id: got %0d want 7", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_done_on_expiry();
    req_valid = 1'b1; req_id = 4'd9;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL exp_start_t: got %b want 1", start); end
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL exp_start_t+%0d: got %b want 0", i, start); end
      if (i == 16) done = 1'b1;
    end
    step();
    done = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL exp_no_retry: got %b want 0", start); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL exp_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL exp_timeout: got %b want 0", rsp_timeout); end
    checks++; if (rsp_id !== 4'd9) begin errors++; $display("FAIL exp_rsp_id: got %0d want 9", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_done_stuck();
    rstn = 1'b0; done = 1'b1;
    step(); step();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stuck_idle_rsp: got %b want 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stuck_idle_busy: got %b want 0", busy); end
    end
    req_valid = 1'b1; req_id = 4'd5;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL stuck_start: got %b want 1", start); end
    step(); step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stuck_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 4'd5) begin errors++; $display("FAIL stuck_rsp_id: got %0d want 5", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stuck_extra_rsp: got %b want 0", rsp_valid); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL stuck_extra_start: got %b want 0", start); end
      step();
    end
    done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_id = 4'd1;
    step();
    req_id = 4'd2;
    step();
    req_id = 4'd3;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL midrst_start: got %b want 1", start); end
    step();
    req_valid = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    rstn = 1'b0;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL midrst_start_clr: got %b want 0", start); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_clr: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_clr: got %b want 0", busy); end
    step();
    rstn = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 30; i++) begin
      done = i[0];
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_rsp: got %b want 0", rsp_valid); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL midrst_stale_start: got %b want 0", start); end
    end
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_on_expiry();
    test_done_stuck();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decrypt_dispatch.md
Name: decrypt_dispatch

Overview:
Request dispatcher directly upstream of the decrypt/validate FSM. It buffers incoming decrypt requests and issues one `start` pulse per request. It waits for the FSM's `done`, guarding the wait with a watchdog and a bounded retry. Each request returns a tagged response, with a timeout flag if the downstream FSM deadlocks, so a hung FSM surfaces as an observable error instead of a silent stall.

Parameters:
ID_W, 4, width of request/response tag
DEPTH, 4, request FIFO entries; power of 2, >=2
TIMEOUT, 16, cycles after a start pulse during which done is accepted; >=4
MAX_RETRY, 1, re-issues of start after a timeout before reporting failure; 0..3

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept a request
req_id  in  ID_W  request tag
start  out  1  one-cycle pulse to the decrypt FSM
done  in  1  completion from the decrypt FSM
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  tag of the completed request
rsp_timeout  out  1  1 = all attempts timed out; 0 = done received
busy  out  1  FSM not in IDLE, or FIFO non-empty

Behaviour:
- Reset (rstn low, async):
  - FIFO emptied; FSM = IDLE; timer and retry count = 0.
  - start, rsp_valid, rsp_timeout, busy = 0; rsp_id = 0.
  - req_ready = 1 from the first cycle after reset release.
- FIFO:
  - push on req_valid && req_ready.
  - req_ready = !full, derived from registered occupancy.
  - Head entry is popped only on the response handshake.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - Pointers wrap mod DEPTH.
  - A push while full is impossible, because req_ready=0.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
  - IDLE: FIFO non-empty -> ISSUE. A request pushed into an empty FIFO in cycle N gives start=1 in cycle N+2.
  - ISSUE: start=1 for exactly this cycle; timer loaded with TIMEOUT; -> WAIT. done is ignored in ISSUE.
  - WAIT, done=1: -> RESPOND with rsp_timeout=0. done is sampled only in WAIT.
  - WAIT, done=0: timer decrements. Once timer reaches 0 with no done, i.e. no done in cycles T+1..T+TIMEOUT after start at cycle T:
    - if retry < MAX_RETRY: retry++, -> ISSUE, so start is re-pulsed at cycle T+TIMEOUT+1.
    - else: -> RESPOND with rsp_timeout=1.
  - done arriving on the same cycle the timer expires counts as success; done wins.
  - RESPOND: rsp_valid=1; rsp_id = head tag; rsp_timeout registered. These are held stable until rsp_ready.
  - On the RESPOND handshake: pop FIFO, clear retry, -> IDLE. The next start is no earlier than 2 cycles later.
- Response latency: done in cycle D gives rsp_valid=1 in cycle D+1.
- A done seen outside WAIT, including a stuck-high done, is ignored. It never produces a response and never pops the FIFO.
- Reset asserted mid-operation: the in-flight request and all queued requests are dropped; no response is produced for them.
- Exactly one request is in flight at any time.
- Formal obligations, written as properties in the block:
  - every ISSUE is followed by RESPOND within (MAX_RETRY+1)*(TIMEOUT+1)+1 cycles;
  - start is never high on two consecutive cycles;
  - rsp_* are stable while rsp_valid && !rsp_ready.

Test Plan:
- Reset release, push id=3, FSM returns done 3 cycles after start -> start pulses once at push+2; rsp_valid at done+1 with rsp_id=3, rsp_timeout=0.
- Push ids 1,2,3,4 back-to-back with rsp_ready=0 -> req_ready falls after the 4th push. A 5th req_valid is held off. First rsp_id=1 stays stable until rsp_ready=1.
- done never asserted, TIMEOUT=16, MAX_RETRY=1 -> start at T and again at T+17; rsp_valid with rsp_timeout=1 at T+34.
- done asserted exactly on timer expiry (cycle T+16) -> no retry; rsp_timeout=0.
- done held high continuously from reset -> no response produced while the FIFO is empty; after a push, one response only.
- rstn pulsed low while in WAIT with 2 requests queued -> start=0 and rsp_valid=0 immediately; busy=0; req_ready=1 after release; no stale response.
